alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control FSM that sequences the 8-bit ALU for the microprocessor core.
- Accepts one encoded instruction over a valid/ready handshake and reads source operands from the register file.
- Drives the ALU control and operand inputs, then writes the result back and owns the condition-code register (CCR).
- Sits between the instruction decode/fetch stage and the ALU plus register file.

Parameters:
- RESET_CCR, 4'b0000, CCR value loaded on reset. Bit order {C,V,Z,N}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  8  [7:4] opcode, [3:2] ra, [1:0] rb.
- rf_rd_addr_a / rf_rd_addr_b  out  2 each  register-file read addresses; reads are combinational.
- rf_rd_data_a / rf_rd_data_b  in  8 each  register-file read data.
- rf_we  out  1  register-file write enable.
- rf_wr_addr  out  2  register-file write address.
- rf_wr_data  out  8  register-file write data.
- alu_op  out  4  ALU operation select.
- alu_ra_field  out  2  ALU sub-operation select.
- alu_dec_ra  out  1  ALU decrement-ra select.
- alu_c_in  out  1  ALU carry in.
- alu_operand_a / alu_operand_b  out  8 each  ALU operands.
- alu_old_flags  out  4  current CCR passed to the ALU, {C,V,Z,N}.
- alu_result  in  8  ALU result.
- alu_flags  in  4  ALU flag outputs, {C,V,Z,N}.
- alu_flags_update  in  1  ALU flag-update qualifier.
- ccr  out  4  architectural flags, {C,V,Z,N}.
- done  out  1  one-cycle pulse when an instruction retires.
- loop_taken  out  1  qualified by done; LOOP result was nonzero.
- illegal  out  1  qualified by done; opcode was illegal.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State returns to IDLE; IR=0; CCR=RESET_CCR; captured result and flag registers = 0.
  - rf_we=0, done=0, illegal=0, loop_taken=0, instr_ready=1 (IDLE).
  - Reset asserted in EXEC or WB aborts the instruction: no register write, no CCR change.
- States: IDLE, EXEC, WB (encoding in package).
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr into IR and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - instr_ready=0.
  - rf_rd_addr_a=IR.ra, rf_rd_addr_b=IR.rb.
  - ALU inputs: operand_a=rf_rd_data_a, operand_b=rf_rd_data_b, c_in=CCR.C, old_flags=CCR.
  - Register alu_result, alu_flags and alu_flags_update at the clock edge, then go to WB.
- WB:
  - instr_ready=0; done=1.
  - rf_we per the table below; rf_wr_data = registered result.
  - If the registered flags_update=1 and the opcode is legal, CCR <= registered flags.
  - Go to IDLE.
- Throughput: one instruction per 3 cycles. Accept at edge T, EXEC in cycle T+1, done high in cycle T+2, new CCR visible from T+3.
- ALU drive outside EXEC: alu_op=0, dec_ra=0, remaining ALU outputs hold their last value (don't-care).
- Opcode table (alu_op, ra_field, dec_ra -> write target):
  - 0 NOP: alu_op=0, no write, CCR unchanged.
  - 1 MOV: alu_op=1, write ra <- rb.
  - 2 ADD, 3 SUB, 4 AND, 5 OR: alu_op=opcode, write ra.
  - 6 SHIFT/CARRY: alu_op=6, ra_field=IR.ra.
    - ra 0 (RLC) and ra 1 (RRC): write rb.
    - ra 2 (SETC) and ra 3 (CLRC): no write.
  - 8 UNARY: alu_op=8, dec_ra=0, ra_field=IR.ra; NOT/NEG/INC/DEC applied to rb, write rb.
  - 10 LOOP: alu_op=8, dec_ra=1, write ra; loop_taken=(result!=0).
  - 7, 9, 11-15: illegal. alu_op=0, illegal=1 in WB, no write, CCR unchanged.
- ra_field is driven from IR.ra for every opcode.
- loop_taken=0 for every opcode except LOOP.
- While busy (EXEC/WB), a pending instr_valid is held by the upstream and is not accepted.
- instr is sampled only at the accepting edge.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants (OP_NOP..OP_LOOP);
  - ALU op codes 1-6 and 8;
  - state encoding;
  - CCR bit indices (CCR_C=3, CCR_V=2, CCR_Z=1, CCR_N=0).
- No sub-module is needed. The decoder is a combinational function inside the package or module.

Test Plan:
- ADD: R0=0x7F, R1=0x01, instr 0x21 -> WB: rf_we=1, addr 0, data 0x80; ccr=4'b0101 from T+3; done high at T+2 only.
- SUB to zero: R2=0x05, instr 0x3A -> R2=0x00 written; ccr=4'b1010.
- RLC: R3=0x81, CCR.C=1, instr 0x63 -> rb write R3=0x03; ccr=4'b1100.
- SETC then illegal: SETC 0x68 from CCR=0 -> rf_we=0, ccr=4'b1000. Then 0x70 -> illegal=1 with done, rf_we=0, ccr stays 4'b1000.
- LOOP: R1=0x02, 0xA4 -> R1=0x01, loop_taken=1. Repeat -> R1=0x00, Z=1, loop_taken=0.
- Backpressure/reset: hold instr_valid=1 continuously -> instr_ready low in EXEC/WB, exactly one accept per 3 cycles. Assert rst during EXEC of 0x21 -> no rf_we, ccr=RESET_CCR, instr_ready=1 immediately.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, ALU codes, state encoding and decoder for alu_sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_SHIFT = 4'd6;
  localparam logic [3:0] OP_UNARY = 4'd8;
  localparam logic [3:0] OP_LOOP  = 4'd10;

  localparam logic [3:0] ALU_NONE  = 4'd0;
  localparam logic [3:0] ALU_MOV   = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_SHIFT = 4'd6;
  localparam logic [3:0] ALU_UNARY = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam int CCR_C = 3;
  localparam int CCR_V = 2;
  localparam int CCR_Z = 1;
  localparam int CCR_N = 0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       dec_ra;
    logic       legal;
    logic       we;
    logic       wr_rb;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] opc, input logic [1:0] ra);
    dec_t d;
    d = '0;
    case (opc)
      OP_NOP: d.legal = 1'b1;
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d.alu_op = opc;
        d.legal  = 1'b1;
        d.we     = 1'b1;
      end
      OP_SHIFT: begin
        // RLC/RRC (ra 0/1) write rb; SETC/CLRC only touch the carry
        d.alu_op = ALU_SHIFT;
        d.legal  = 1'b1;
        d.we     = ~ra[1];
        d.wr_rb  = 1'b1;
      end
      OP_UNARY: begin
        d.alu_op = ALU_UNARY;
        d.legal  = 1'b1;
        d.we     = 1'b1;
        d.wr_rb  = 1'b1;
      end
      OP_LOOP: begin
        d.alu_op = ALU_UNARY;
        d.dec_ra = 1'b1;
        d.legal  = 1'b1;
        d.we     = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : three-cycle IDLE/EXEC/WB sequencer for the 8-bit ALU, owns CCR
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [3:0] RESET_CCR = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  output logic [1:0] rf_rd_addr_a,
  output logic [1:0] rf_rd_addr_b,
  input  logic [7:0] rf_rd_data_a,
  input  logic [7:0] rf_rd_data_b,
  output logic       rf_we,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic [3:0] alu_op,
  output logic [1:0] alu_ra_field,
  output logic       alu_dec_ra,
  output logic       alu_c_in,
  output logic [7:0] alu_operand_a,
  output logic [7:0] alu_operand_b,
  output logic [3:0] alu_old_flags,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
  input  logic       alu_flags_update,
  output logic [3:0] ccr,
  output logic       done,
  output logic       loop_taken,
  output logic       illegal
);

  logic [1:0] r_state;
  logic [7:0] r_ir;
  logic [3:0] r_ccr;
  logic [7:0] r_res;
  logic [3:0] r_flags;
  logic       r_fupd;
  dec_t       w_dec;
  logic       w_exec;

  assign w_dec  = decode(r_ir[7:4], r_ir[3:2]);
  assign w_exec = (r_state == ST_EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ir    <= 8'h00;
      r_ccr   <= RESET_CCR;
      r_res   <= 8'h00;
      r_flags <= 4'h0;
      r_fupd  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res   <= alu_result;
          r_flags <= alu_flags;
          r_fupd  <= alu_flags_update;
          r_state <= ST_WB;
        end
        ST_WB: begin
          if (r_fupd && w_dec.legal) begin
            r_ccr <= r_flags;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready   = (r_state == ST_IDLE);
  assign done          = (r_state == ST_WB);

  // Operand paths are wired through permanently; only op/dec_ra are qualified by EXEC
  assign rf_rd_addr_a  = r_ir[3:2];
  assign rf_rd_addr_b  = r_ir[1:0];
  assign alu_operand_a = rf_rd_data_a;
  assign alu_operand_b = rf_rd_data_b;
  assign alu_c_in      = r_ccr[CCR_C];
  assign alu_old_flags = r_ccr;
  assign alu_ra_field  = r_ir[3:2];
  assign alu_op        = w_exec ? w_dec.alu_op : ALU_NONE;
  assign alu_dec_ra    = w_exec & w_dec.dec_ra;

  assign rf_we         = done & w_dec.we;
  assign rf_wr_addr    = w_dec.wr_rb ? r_ir[1:0] : r_ir[3:2];
  assign rf_wr_data    = r_res;

  assign ccr           = r_ccr;
  assign illegal       = done & ~w_dec.legal;
  assign loop_taken    = done & (r_ir[7:4] == OP_LOOP) & (r_res != 8'h00);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : bench with ALU/register-file models and an ISA-level checker
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam logic [3:0] TB_RESET_CCR = 4'b0000;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [7:0] rf_rd_data_a, rf_rd_data_b;
  logic       rf_we;
  logic [1:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [3:0] alu_op;
  logic [1:0] alu_ra_field;
  logic       alu_dec_ra;
  logic       alu_c_in;
  logic [7:0] alu_operand_a, alu_operand_b;
  logic [3:0] alu_old_flags;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       alu_flags_update;
  logic [3:0] ccr;
  logic       done, loop_taken, illegal;

  alu_sequencer #(.RESET_CCR(TB_RESET_CCR)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_op(alu_op), .alu_ra_field(alu_ra_field), .alu_dec_ra(alu_dec_ra),
    .alu_c_in(alu_c_in), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_old_flags(alu_old_flags), .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_flags_update(alu_flags_update), .ccr(ccr), .done(done),
    .loop_taken(loop_taken), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU semantics by operation kind: returns {update, flags{C,V,Z,N}, result}
  // kinds: 0 none, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 RLC, 7 RRC, 8 SETC,
  //        9 CLRC, 10 NOT, 11 NEG, 12 INC, 13 DEC, 14 decrement of operand a
  function automatic logic [12:0] alu_fn(input int k, input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic [3:0] old);
    logic [8:0] w;
    logic [7:0] r;
    logic [3:0] f;
    logic       u;
    u = 1'b1; f = old; r = 8'h00; w = 9'h000;
    case (k)
      1: r = b;
      2: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; f[3] = w[8];
               f[2] = (a[7] == b[7]) && (r[7] != a[7]); end
      3: begin w = {1'b0, a} + {1'b0, ~b} + 9'd1; r = w[7:0]; f[3] = w[8];
               f[2] = (a[7] != b[7]) && (r[7] != a[7]); end
      4: begin r = a & b; f[2] = 1'b0; end
      5: begin r = a | b; f[2] = 1'b0; end
      6: begin r = {b[6:0], c}; f[3] = b[7]; f[2] = r[7] ^ b[7]; end
      7: begin r = {c, b[7:1]}; f[3] = b[0]; f[2] = r[7] ^ b[0]; end
      8: begin r = b; f[3] = 1'b1; end
      9: begin r = b; f[3] = 1'b0; end
      10: begin r = ~b; f[2] = 1'b0; end
      11: begin r = 8'h00 - b; f[3] = (b != 8'h00); f[2] = (b == 8'h80); end
      12: begin r = b + 8'h01; f[2] = (b == 8'h7F); end
      13: begin r = b - 8'h01; f[2] = (b == 8'h80); end
      14: begin r = a - 8'h01; f[2] = (a == 8'h80); end
      default: u = 1'b0;
    endcase
    if (u && k != 8 && k != 9) begin
      f[1] = (r == 8'h00);
      f[0] = r[7];
    end
    return {u, f, r};
  endfunction

  function automatic int alu_kind(input logic [3:0] op, input logic [1:0] sub, input logic d);
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return int'(op);
      4'd6: return 6 + int'(sub);
      4'd8: return d ? 14 : 10 + int'(sub);
      default: return 0;
    endcase
  endfunction

  logic [12:0] alu_out;
  always_comb begin
    alu_out = alu_fn(alu_kind(alu_op, alu_ra_field, alu_dec_ra), alu_operand_a, alu_operand_b,
                     alu_c_in, alu_old_flags);
  end
  assign alu_flags_update = alu_out[12];
  assign alu_flags        = alu_out[11:8];
  assign alu_result       = alu_out[7:0];

  // Register file, with a bench-side preload port
  logic [7:0] rf [4];
  logic       pre_we;
  logic [1:0] pre_addr;
  logic [7:0] pre_data;
  assign rf_rd_data_a = rf[rf_rd_addr_a];
  assign rf_rd_data_b = rf[rf_rd_addr_b];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
  end

  // Instruction-level reference model
  typedef struct packed {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       upd;
    logic [3:0] flags;
    logic       ill;
    logic       loop;
    logic [3:0] op;
    logic       dec;
    logic [1:0] raf;
  } exp_t;

  function automatic exp_t predict(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] cc);
    exp_t        e;
    int          k;
    logic [12:0] o;
    logic [3:0]  opc;
    logic [1:0]  ra, rb;
    e = '0; k = 0;
    opc = ins[7:4]; ra = ins[3:2]; rb = ins[1:0];
    e.raf = ra;
    case (opc)
      4'd0: k = 0;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin k = int'(opc); e.we = 1'b1; e.addr = ra; e.op = opc; end
      4'd6: begin k = 6 + int'(ra); e.we = (ra < 2'd2); e.addr = rb; e.op = 4'd6; end
      4'd8: begin k = 10 + int'(ra); e.we = 1'b1; e.addr = rb; e.op = 4'd8; end
      4'd10: begin k = 14; e.we = 1'b1; e.addr = ra; e.op = 4'd8; e.dec = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    o = alu_fn(k, a, b, cc[3], cc);
    e.data  = o[7:0];
    e.flags = o[11:8];
    e.upd   = o[12] & ~e.ill;
    e.loop  = (opc == 4'd10) && (e.data != 8'h00);
    return e;
  endfunction

  int         m_phase;
  logic [3:0] m_ccr;
  exp_t       m_exp;
  logic [7:0] m_rf [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_ccr   <= TB_RESET_CCR;
      m_exp   <= '0;
    end else if (m_phase == 0) begin
      if (instr_valid) begin
        m_exp   <= predict(instr, m_rf[instr[3:2]], m_rf[instr[1:0]], m_ccr);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else begin
      if (m_exp.upd) m_ccr <= m_exp.flags;
      m_phase <= 0;
    end
  end

  always @(posedge clk) begin
    if (pre_we) m_rf[pre_addr] <= pre_data;
    else if (!rst && m_phase == 2 && m_exp.we) m_rf[m_exp.addr] <= m_exp.data;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    if (!rst) begin
      check("instr_ready", instr_ready, 8'(m_phase == 0));
      check("done", done, 8'(m_phase == 2));
      check("rf_we", rf_we, 8'(m_phase == 2 && m_exp.we));
      check("ccr", ccr, m_ccr);
      if (m_phase == 1) begin
        check("alu_op", alu_op, m_exp.op);
        check("alu_dec_ra", alu_dec_ra, m_exp.dec);
        check("alu_ra_field", alu_ra_field, m_exp.raf);
        check("alu_c_in", alu_c_in, m_ccr[3]);
        check("alu_old_flags", alu_old_flags, m_ccr);
      end else begin
        check("alu_op_idle", alu_op, 8'h00);
        check("alu_dec_ra_idle", alu_dec_ra, 8'h00);
      end
      if (m_phase == 2) begin
        check("illegal", illegal, m_exp.ill);
        check("loop_taken", loop_taken, m_exp.loop);
        if (m_exp.we) begin
          check("rf_wr_addr", rf_wr_addr, m_exp.addr);
          check("rf_wr_data", rf_wr_data, m_exp.data);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [7:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    tick();
    pre_we = 1'b0;
  endtask

  logic       wb_done, wb_loop, wb_ill, wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [3:0] wb_ccr;

  // Issue one instruction from a negedge; returns at the negedge after WB
  task automatic issue(input logic [7:0] ins);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) check("ready_timeout", 8'h00, 8'h01);
    instr_valid = 1'b1;
    instr = ins;
    tick();
    instr_valid = 1'b0;
    instr = 8'($urandom);
    tick();
    wb_done = done; wb_loop = loop_taken; wb_ill = illegal;
    wb_we = rf_we; wb_addr = rf_wr_addr; wb_data = rf_wr_data; wb_ccr = ccr;
    tick();
  endtask

  logic [7:0] extra [18];
  int         accepts;

  initial begin
    extra = '{8'h16, 8'h44, 8'h59, 8'h61, 8'h6D, 8'h6E, 8'h6F, 8'h80, 8'h85,
              8'h8A, 8'h8F, 8'h90, 8'hB0, 8'hC5, 8'hFF, 8'h00, 8'h2B, 8'h37};
    rst = 1'b1; instr_valid = 1'b0; instr = 8'h00;
    pre_we = 1'b0; pre_addr = 2'd0; pre_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_ready", instr_ready, 8'h01);
    check("reset_done", done, 8'h00);
    check("reset_rf_we", rf_we, 8'h00);
    check("reset_illegal", illegal, 8'h00);
    check("reset_loop", loop_taken, 8'h00);
    check("reset_ccr", ccr, 8'(TB_RESET_CCR));
    rst = 1'b0;
    tick();

    set_reg(2'd0, 8'h7F); set_reg(2'd1, 8'h01); set_reg(2'd2, 8'h05); set_reg(2'd3, 8'h81);

    issue(8'h21);
    check("add_done", wb_done, 8'h01);
    check("add_we", wb_we, 8'h01);
    check("add_addr", wb_addr, 8'h00);
    check("add_data", wb_data, 8'h80);
    check("add_ccr_in_wb", wb_ccr, 8'h00);
    check("add_ccr", ccr, 8'h05);
    check("add_done_after", done, 8'h00);
    check("add_rf0", rf[0], 8'h80);

    issue(8'h3A);
    check("sub_rf2", rf[2], 8'h00);
    check("sub_ccr", ccr, 8'h0A);

    issue(8'h63);
    check("rlc_addr", wb_addr, 8'h03);
    check("rlc_rf3", rf[3], 8'h03);
    check("rlc_ccr", ccr, 8'h0C);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();

    issue(8'h68);
    check("setc_we", wb_we, 8'h00);
    check("setc_ccr", ccr, 8'h08);
    issue(8'h70);
    check("ill_flag", wb_ill, 8'h01);
    check("ill_done", wb_done, 8'h01);
    check("ill_we", wb_we, 8'h00);
    check("ill_ccr", ccr, 8'h08);

    set_reg(2'd1, 8'h02);
    issue(8'hA4);
    check("loop1_rf1", rf[1], 8'h01);
    check("loop1_taken", wb_loop, 8'h01);
    issue(8'hA4);
    check("loop2_rf1", rf[1], 8'h00);
    check("loop2_taken", wb_loop, 8'h00);
    check("loop2_z", ccr[1], 8'h01);

    // Continuous valid: one accept every third cycle
    accepts = 0;
    instr_valid = 1'b1; instr = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) accepts++;
      tick();
    end
    instr_valid = 1'b0;
    check("bp_accepts", 8'(accepts), 8'h03);

    // Reset while the ADD is in EXEC must abort it
    set_reg(2'd0, 8'h7F); set_reg(2'd1, 8'h01);
    instr_valid = 1'b1; instr = 8'h21;
    tick();
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_ready", instr_ready, 8'h01);
    check("abort_we", rf_we, 8'h00);
    check("abort_ccr", ccr, 8'(TB_RESET_CCR));
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    check("abort_rf0", rf[0], 8'h7F);

    set_reg(2'd0, 8'h80); set_reg(2'd1, 8'h3C); set_reg(2'd2, 8'hFF); set_reg(2'd3, 8'h01);
    for (int i = 0; i < 18; i++) issue(extra[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
